// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor and its Gray-code
// clock-domain counters.
package pll_mon_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASELINE,
    ST_MEASURE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Free-running edge counter in src_clk, carried to dst_clk as registered Gray
// code through a 2-flop synchronizer and decoded back to binary.
module gray_sync
  import pll_mon_pkg::*;
#(
  parameter logic [CNT_W-1:0] INIT = '0
) (
  input  logic             src_clk,
  input  logic             dst_clk,
  input  logic             rst,
  output logic [CNT_W-1:0] dst_count
);

  logic [1:0]       src_rst_sync;
  logic             src_rst;
  logic [CNT_W-1:0] bin_cnt;
  logic [CNT_W-1:0] gray_q;
  logic [CNT_W-1:0] sync1;
  logic [CNT_W-1:0] sync2;

  // Source-domain reset: asserts with rst, releases two src_clk edges later.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      src_rst_sync <= 2'b11;
    end else begin
      src_rst_sync <= {src_rst_sync[0], 1'b0};
    end
  end

  assign src_rst = src_rst_sync[1];

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      bin_cnt <= INIT;
      gray_q  <= bin2gray(INIT);
    end else begin
      bin_cnt <= bin_cnt + 1'b1;
      gray_q  <= bin2gray(bin_cnt);
    end
  end

  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      sync1 <= bin2gray(INIT);
      sync2 <= bin2gray(INIT);
    end else begin
      sync1 <= gray_q;
      sync2 <= sync1;
    end
  end

  assign dst_count = gray2bin(sync2);

endmodule

// File: rtl/pll_lock_mon.sv
// Measures gclk against clk over fixed windows, declares lock after enough
// consecutive in-tolerance windows, and generates the gclk-domain reset.
module pll_lock_mon
  import pll_mon_pkg::*;
#(
  parameter int REF_WINDOW   = 1024,
  parameter int EXP_COUNT    = 2048,
  parameter int TOL          = 8,
  parameter int LOCK_WINDOWS = 4,
  parameter int MAX_WINDOWS  = 64,
  parameter int RST_STRETCH  = 16,
  // Reset value of the gclk edge counter; nonzero only to exercise wrap.
  parameter logic [CNT_W-1:0] GCNT_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gclk,
  input  logic             idt_ready,
  output logic             locked,
  output logic             fail,
  output logic             lost_lock,
  output logic [CNT_W-1:0] meas_count,
  output logic             grst,
  output state_t           state
);

  localparam int WIN_W = $clog2(REF_WINDOW);
  localparam int WC_W  = $clog2(MAX_WINDOWS + 1);
  localparam int STR_W = $clog2(RST_STRETCH + 1);
  localparam logic signed [CNT_W:0] EXP_S = EXP_COUNT;
  localparam logic signed [CNT_W:0] TOL_S = TOL;

  logic [CNT_W-1:0]        sync_count;
  logic [CNT_W-1:0]        sample;
  logic [CNT_W-1:0]        prev;
  logic [CNT_W-1:0]        delta;
  logic signed [CNT_W:0]   dev;
  logic                    good;
  logic [WIN_W-1:0]        win_pos;
  logic                    tc;
  logic                    eval_pend;
  logic [3:0]              good_cnt;
  logic [WC_W-1:0]         win_cnt;
  logic                    lock_now;
  logic                    grst_arst;
  logic [1:0]              lock_sync;
  logic [STR_W-1:0]        stretch;

  gray_sync #(.INIT(GCNT_INIT)) u_gray_sync (
    .src_clk   (gclk),
    .dst_clk   (clk),
    .rst       (rst),
    .dst_count (sync_count)
  );

  assign tc       = (win_pos == WIN_W'(REF_WINDOW - 1));
  assign delta    = sample - prev;
  assign dev      = $signed({1'b0, delta}) - EXP_S;
  assign good     = (dev <= TOL_S) && (dev >= -TOL_S);
  assign lock_now = good && (good_cnt == 4'(LOCK_WINDOWS - 1));

  // Window timing: the terminal count captures the sample; the verdict is
  // taken by the FSM on the following edge while eval_pend is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_pos   <= '0;
      sample    <= '0;
      eval_pend <= 1'b0;
    end else begin
      eval_pend <= 1'b0;
      if (state == ST_IDLE || state == ST_FAIL) begin
        win_pos <= '0;
      end else if (tc) begin
        win_pos   <= '0;
        sample    <= sync_count;
        eval_pend <= 1'b1;
      end else begin
        win_pos <= win_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev       <= '0;
      meas_count <= '0;
      good_cnt   <= '0;
      win_cnt    <= '0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      lost_lock  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idt_ready) state <= ST_BASELINE;
        end
        ST_BASELINE: begin
          if (eval_pend) begin
            prev  <= sample;
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (eval_pend) begin
            prev       <= sample;
            meas_count <= delta;
            win_cnt    <= win_cnt + 1'b1;
            good_cnt   <= good ? good_cnt + 1'b1 : 4'd0;
            if (lock_now) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else if (win_cnt == WC_W'(MAX_WINDOWS - 1)) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (eval_pend) begin
            prev       <= sample;
            meas_count <= delta;
            if (!good) begin
              state     <= ST_MEASURE;
              locked    <= 1'b0;
              lost_lock <= 1'b1;
              good_cnt  <= '0;
              win_cnt   <= '0;
            end
          end
        end
        ST_FAIL: begin
          state <= ST_FAIL;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Dropping lock forces grst high without needing gclk; release is a
  // synchronized locked followed by RST_STRETCH gclk cycles.
  assign grst_arst = rst | ~locked;

  always_ff @(posedge gclk or posedge grst_arst) begin
    if (grst_arst) begin
      lock_sync <= 2'b00;
      stretch   <= '0;
      grst      <= 1'b1;
    end else begin
      lock_sync <= {lock_sync[0], 1'b1};
      if (lock_sync[1] && grst) begin
        if (stretch == STR_W'(RST_STRETCH - 1)) begin
          grst <= 1'b0;
        end else begin
          stretch <= stretch + 1'b1;
        end
      end
    end
  end

endmodule
